// File: rtl/waverforms_osc_core.sv
// Phase-accumulator oscillator: one signed sample per valid/ready handshake.
// Shadowed configuration and phase reset are applied only at sample boundaries.
module waverforms_osc_core #(
  parameter int PHASE_WIDTH  = 32,
  parameter int SAMPLE_WIDTH = 32  // must equal PHASE_WIDTH
) (
  input  logic                    ap_clk,
  input  logic                    ap_rst,
  input  logic                    enable,
  input  logic                    cfg_we,
  input  logic [PHASE_WIDTH-1:0]  phase_inc,
  input  logic [1:0]              wave_sel,
  input  logic [PHASE_WIDTH-1:0]  duty,
  input  logic                    phase_reset,
  output logic [SAMPLE_WIDTH-1:0] sample_out,
  output logic                    sample_valid,
  input  logic                    sample_ready,
  output logic                    wrap
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  localparam logic [1:0] WAVE_SAW    = 2'd0;
  localparam logic [1:0] WAVE_SQUARE = 2'd1;
  localparam logic [1:0] WAVE_TRI    = 2'd2;

  localparam logic [PHASE_WIDTH-1:0] C_MSB  = {1'b1, {(PHASE_WIDTH-1){1'b0}}};
  localparam logic [PHASE_WIDTH-1:0] C_HIGH = ~C_MSB;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [PHASE_WIDTH-1:0]   r_phase;
  logic [SAMPLE_WIDTH-1:0]  r_sample;
  logic                     r_wrap;
  logic                     r_reset_pending;
  logic [PHASE_WIDTH-1:0]   r_sh_inc;
  logic [1:0]               r_sh_sel;
  logic [PHASE_WIDTH-1:0]   r_sh_duty;
  logic [PHASE_WIDTH-1:0]   r_inc;
  logic [1:0]               r_sel;
  logic [PHASE_WIDTH-1:0]   r_duty;

  logic                     w_start;
  logic                     w_accept;
  logic                     w_boundary;
  logic                     w_zero;
  logic [PHASE_WIDTH:0]     w_sum;
  logic [PHASE_WIDTH-1:0]   w_next_phase;
  logic [PHASE_WIDTH-1:0]   w_eff_inc;
  logic [1:0]               w_eff_sel;
  logic [PHASE_WIDTH-1:0]   w_eff_duty;

  // Signed sample as offset binary: flipping the MSB maps phase 0 to the most negative value.
  function automatic logic [SAMPLE_WIDTH-1:0] shape(
    input logic [1:0]             sel,
    input logic [PHASE_WIDTH-1:0] duty_v,
    input logic [PHASE_WIDTH-1:0] p
  );
    logic [PHASE_WIDTH-1:0] fold;
    fold = p[PHASE_WIDTH-1] ? ~p : p;
    case (sel)
      WAVE_SAW:    shape = p ^ C_MSB;
      WAVE_SQUARE: shape = (p < duty_v) ? C_HIGH : C_MSB;
      WAVE_TRI:    shape = (fold << 1) ^ C_MSB;
      default:     shape = '0;
    endcase
  endfunction

  // NOTE: every signal assigned in always_comb gets a value on every path; the
  // leading defaults are what keep these blocks from inferring latches.
  always_comb begin
    w_start      = (r_state == S_IDLE) && enable;
    w_accept     = (r_state == S_RUN) && sample_ready;
    w_boundary   = w_start || w_accept;
    w_zero       = phase_reset || r_reset_pending;
    w_eff_inc    = cfg_we ? phase_inc : r_sh_inc;
    w_eff_sel    = cfg_we ? wave_sel  : r_sh_sel;
    w_eff_duty   = cfg_we ? duty      : r_sh_duty;
    w_sum        = {1'b0, r_phase} + {1'b0, r_inc};
    w_next_phase = r_phase;
    if (w_zero) begin
      w_next_phase = '0;
    end else if (w_accept) begin
      w_next_phase = w_sum[PHASE_WIDTH-1:0];
    end
  end

  // NOTE: clocked state uses non-blocking assignments so every register samples
  // pre-edge values and simulation order between processes cannot matter.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (enable) w_state_nxt = S_RUN;
      S_RUN:  if (sample_ready && !enable) w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    sample_valid = (r_state == S_RUN);
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      r_phase         <= '0;
      r_sample        <= '0;
      r_wrap          <= 1'b0;
      r_reset_pending <= 1'b0;
      r_sh_inc        <= '0;
      r_sh_sel        <= WAVE_SAW;
      r_sh_duty       <= C_MSB;
      r_inc           <= '0;
      r_sel           <= WAVE_SAW;
      r_duty          <= C_MSB;
    end else begin
      // A forced zero phase is a reset, not a carry, so it never pulses wrap.
      r_wrap <= w_accept && !w_zero && w_sum[PHASE_WIDTH];
      if (cfg_we) begin
        r_sh_inc  <= phase_inc;
        r_sh_sel  <= wave_sel;
        r_sh_duty <= duty;
      end
      if (w_boundary) begin
        r_inc           <= w_eff_inc;
        r_sel           <= w_eff_sel;
        r_duty          <= w_eff_duty;
        r_phase         <= w_next_phase;
        r_sample        <= shape(w_eff_sel, w_eff_duty, w_next_phase);
        r_reset_pending <= 1'b0;
      end else if (phase_reset) begin
        r_reset_pending <= 1'b1;
      end
    end
  end

  // Active select/duty are kept for visibility of the sample's configuration.
  logic w_unused_cfg;
  assign w_unused_cfg = ^{r_sel, r_duty};

  assign sample_out = r_sample;
  assign wrap       = r_wrap;

endmodule

// File: tb/tb_waverforms_osc_core.sv
// Self-checking bench: per-cycle behavioural model plus directed literal sequences.
module tb_waverforms_osc_core;

  logic        ap_clk       = 1'b0;
  logic        ap_rst       = 1'b1;
  logic        enable       = 1'b0;
  logic        cfg_we       = 1'b0;
  logic [31:0] phase_inc    = '0;
  logic [1:0]  wave_sel     = '0;
  logic [31:0] duty         = '0;
  logic        phase_reset  = 1'b0;
  logic        sample_ready = 1'b0;
  logic [31:0] sample_out;
  logic        sample_valid;
  logic        wrap;

  waverforms_osc_core #(.PHASE_WIDTH(32), .SAMPLE_WIDTH(32)) dut (
    .ap_clk      (ap_clk),
    .ap_rst      (ap_rst),
    .enable      (enable),
    .cfg_we      (cfg_we),
    .phase_inc   (phase_inc),
    .wave_sel    (wave_sel),
    .duty        (duty),
    .phase_reset (phase_reset),
    .sample_out  (sample_out),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .wrap        (wrap)
  );

  always #5 ap_clk = ~ap_clk;

  int          n_cmp  = 0;
  int          n_fail = 0;
  bit          chk_on = 1'b0;
  logic [31:0] acc_q[$];
  logic [31:0] exp_q[$];
  int          wrap_q[$];

  // Model state: what the oscillator must hold after each clock edge.
  logic [31:0] m_phase, m_inc, m_duty, m_sh_inc, m_sh_duty, m_sample;
  logic [1:0]  m_sel, m_sh_sel;
  bit          m_run, m_pend, m_wrap;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_wave(input logic [1:0] sel, input logic [31:0] dty,
                                             input logic [31:0] p);
    longint unsigned fold;
    logic [31:0] r;
    r = 32'h0;
    case (sel)
      2'd0: r = p + 32'h8000_0000;
      2'd1: r = (p < dty) ? 32'h7FFF_FFFF : 32'h8000_0000;
      2'd2: begin
        fold = (p < 32'h8000_0000) ? 64'(p) : 64'hFFFF_FFFF - 64'(p);
        r    = 32'(2 * fold - 64'h8000_0000);
      end
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  task automatic model_reset();
    m_phase = '0; m_inc = '0; m_sel = '0; m_duty = 32'h8000_0000;
    m_sh_inc = '0; m_sh_sel = '0; m_sh_duty = 32'h8000_0000;
    m_sample = '0; m_run = 1'b0; m_pend = 1'b0; m_wrap = 1'b0;
  endtask

  task automatic model_step();
    bit             accept, bound;
    longint unsigned sum;
    accept = m_run && sample_ready;
    bound  = accept || (!m_run && enable);
    m_wrap = 1'b0;
    if (bound) begin
      sum = 64'(m_phase) + 64'(m_inc);
      if (phase_reset || m_pend) begin
        m_phase = '0;
      end else if (accept) begin
        m_phase = 32'(sum);
        m_wrap  = (sum >= 64'h1_0000_0000);
      end
      m_inc    = cfg_we ? phase_inc : m_sh_inc;
      m_sel    = cfg_we ? wave_sel  : m_sh_sel;
      m_duty   = cfg_we ? duty      : m_sh_duty;
      m_sample = model_wave(m_sel, m_duty, m_phase);
      m_pend   = 1'b0;
      m_run    = accept ? enable : 1'b1;
    end else if (phase_reset) begin
      m_pend = 1'b1;
    end
    if (cfg_we) begin
      m_sh_inc = phase_inc; m_sh_sel = wave_sel; m_sh_duty = duty;
    end
  endtask

  always @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) model_reset();
    else        model_step();
  end

  // Compare process: record handshakes and wrap pulses, then check against the model.
  always @(negedge ap_clk) begin
    if (chk_on) begin
      if (wrap === 1'b1) wrap_q.push_back(acc_q.size());
      if (sample_valid === 1'b1 && sample_ready) acc_q.push_back(sample_out);
      check("valid", 32'(sample_valid), 32'(m_run));
      check("wrap", 32'(wrap), 32'(m_wrap));
      if (m_run) check("sample", sample_out, m_sample);
    end
  end

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic start_seg(input logic [31:0] inc, input logic [1:0] sel, input logic [31:0] dty);
    enable       = 1'b0;
    sample_ready = 1'b0;
    ap_rst       = 1'b1;
    tick();
    ap_rst    = 1'b0;
    phase_inc = inc;
    wave_sel  = sel;
    duty      = dty;
    cfg_we    = 1'b1;
    tick();
    cfg_we = 1'b0;
    acc_q.delete();
    wrap_q.delete();
    enable = 1'b1;
  endtask

  task automatic collect(input int n);
    sample_ready = 1'b1;
    for (int i = 0; i < n * 4 + 8 && acc_q.size() < n; i++) tick();
    sample_ready = 1'b0;
    check("accept_count", 32'(acc_q.size()), 32'(n));
  endtask

  task automatic check_seq(input string name);
    for (int i = 0; i < exp_q.size(); i++) begin
      check($sformatf("%s[%0d]", name, i), (i < acc_q.size()) ? acc_q[i] : 32'hxxxx_xxxx, exp_q[i]);
    end
  endtask

  task automatic cfg_write(input logic [31:0] inc, input logic [1:0] sel, input logic [31:0] dty);
    phase_inc = inc;
    wave_sel  = sel;
    duty      = dty;
    cfg_we    = 1'b1;
  endtask

  initial begin
    repeat (3) @(posedge ap_clk);
    #1;
    check("rst_sample", sample_out, 32'h0);
    check("rst_valid", 32'(sample_valid), 32'h0);
    check("rst_wrap", 32'(wrap), 32'h0);
    ap_rst = 1'b0;
    chk_on = 1'b1;
    tick();

    // Saw back-to-back, then backpressure and resume.
    start_seg(32'h4000_0000, 2'd0, 32'h8000_0000);
    collect(5);
    exp_q = {32'h8000_0000, 32'hC000_0000, 32'h0000_0000, 32'h4000_0000, 32'h8000_0000};
    check_seq("saw");
    check("saw_wrap_count", 32'(wrap_q.size()), 32'd1);
    if (wrap_q.size() > 0) check("saw_wrap_pos", 32'(wrap_q[0]), 32'd4);
    repeat (5) begin
      tick();
      check("bp_sample", sample_out, 32'hC000_0000);
      check("bp_valid", 32'(sample_valid), 32'd1);
    end
    acc_q.delete();
    collect(3);
    exp_q = {32'hC000_0000, 32'h0000_0000, 32'h4000_0000};
    check_seq("bp_resume");

    // Square with quarter duty.
    start_seg(32'h2000_0000, 2'd1, 32'h4000_0000);
    collect(16);
    exp_q.delete();
    for (int i = 0; i < 16; i++) exp_q.push_back((i % 8 < 2) ? 32'h7FFF_FFFF : 32'h8000_0000);
    check_seq("square");

    // Triangle.
    start_seg(32'h4000_0000, 2'd2, 32'h8000_0000);
    collect(8);
    exp_q = {32'h8000_0000, 32'h0000_0000, 32'h7FFF_FFFE, 32'hFFFF_FFFE,
             32'h8000_0000, 32'h0000_0000, 32'h7FFF_FFFE, 32'hFFFF_FFFE};
    check_seq("tri");

    // Config written under backpressure applies only from the next sample.
    start_seg(32'h4000_0000, 2'd0, 32'h8000_0000);
    collect(1);
    cfg_write(32'h4000_0000, 2'd3, 32'h8000_0000);
    tick();
    cfg_we = 1'b0;
    tick();
    check("cfg_hold", sample_out, 32'hC000_0000);
    acc_q.delete();
    collect(2);
    exp_q = {32'hC000_0000, 32'h0000_0000};
    check_seq("cfg_shadow");

    // Config coincident with an accept takes effect on that accept.
    acc_q.delete();
    wrap_q.delete();
    cfg_write(32'h4000_0000, 2'd0, 32'h8000_0000);
    sample_ready = 1'b1;
    tick();
    cfg_we       = 1'b0;
    sample_ready = 1'b0;
    tick();
    check("cfg_coinc_acc", 32'(acc_q.size()), 32'd1);
    check("cfg_coinc_sample", sample_out, 32'h8000_0000);
    check("cfg_coinc_wrap", 32'(wrap_q.size()), 32'd1);

    // Phase reset while a carry is due: next sample f(0), no wrap.
    acc_q.delete();
    collect(3);
    phase_reset = 1'b1;
    tick();
    phase_reset = 1'b0;
    tick();
    check("prst_hold", sample_out, 32'h4000_0000);
    acc_q.delete();
    wrap_q.delete();
    collect(2);
    exp_q = {32'h4000_0000, 32'h8000_0000};
    check_seq("prst");
    check("prst_no_wrap", 32'(wrap_q.size()), 32'd0);

    // Enable dropped under backpressure: hold, then return to idle on accept.
    enable = 1'b0;
    repeat (3) begin
      tick();
      check("en_hold_valid", 32'(sample_valid), 32'd1);
      check("en_hold_sample", sample_out, 32'hC000_0000);
    end
    sample_ready = 1'b1;
    tick();
    sample_ready = 1'b0;
    tick();
    check("en_idle_valid", 32'(sample_valid), 32'd0);
    enable = 1'b1;
    tick();
    tick();
    check("en_restart_valid", 32'(sample_valid), 32'd1);

    // Asynchronous reset mid-cycle clears outputs without a clock edge.
    start_seg(32'h4000_0000, 2'd0, 32'h8000_0000);
    tick();
    check("pre_rst_sample", sample_out, 32'h8000_0000);
    #2 ap_rst = 1'b1;
    #1;
    check("async_rst_sample", sample_out, 32'h0);
    check("async_rst_valid", 32'(sample_valid), 32'h0);
    check("async_rst_wrap", 32'(wrap), 32'h0);
    tick();
    ap_rst = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
